// File: rtl/gumnut_regfile_flags.sv
// Gumnut architectural register file with live and interrupt-shadow carry/zero flags.
// Reads are combinational from stored state with no write bypass; r0 always reads zero.
module gumnut_regfile_flags #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic              rd_we_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              flag_we_i,
    input  logic              carry_i,
    input  logic              zero_i,
    input  logic              int_save_i,
    input  logic              int_restore_i,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic carry_q, carry_d;
    logic zero_q, zero_d;
    logic sh_carry_q, sh_carry_d;
    logic sh_zero_q, sh_zero_d;

    // Address is usable only if nonzero and inside the implemented range.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < NUM_REGS);
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (rd_we_i && addr_ok(rd_addr_i)) begin
            regs_d[rd_addr_i] = rd_data_i;
        end
    end

    always_comb begin
        rs_data_o  = '0;
        rs2_data_o = '0;
        if (addr_ok(rs_addr_i)) begin
            rs_data_o = regs_q[rs_addr_i];
        end
        if (addr_ok(rs2_addr_i)) begin
            rs2_data_o = regs_q[rs2_addr_i];
        end
    end

    // Restore outranks flag_we; a save always captures the pre-edge live flags.
    always_comb begin
        carry_d    = carry_q;
        zero_d     = zero_q;
        sh_carry_d = sh_carry_q;
        sh_zero_d  = sh_zero_q;
        if (int_restore_i) begin
            carry_d = sh_carry_q;
            zero_d  = sh_zero_q;
        end else if (flag_we_i) begin
            carry_d = carry_i;
            zero_d  = zero_i;
        end
        if (int_save_i) begin
            sh_carry_d = carry_q;
            sh_zero_d  = zero_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q     <= '{default: '0};
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            sh_carry_q <= 1'b0;
            sh_zero_q  <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            sh_carry_q <= sh_carry_d;
            sh_zero_q  <= sh_zero_d;
        end
    end

    assign carry_o = carry_q;
    assign zero_o  = zero_q;

endmodule
